// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial add/subtract engine: FSM state encoding
// and a constant-foldable ceil(log2) helper for sizing the pass counter.
package serial_adder_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ceil(log2(n)); returns 0 for n <= 1, callers clamp to a minimum width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_chunk.sv
// One CHUNK-bit slice of the ripple adder. Purely combinational; the carry
// between slices is held in a register by the parent.
module adder_chunk
    import serial_adder_defs::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign s     = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // Carry into the top bit recovered from its sum bit: s = x ^ y ^ cin.
    assign c_msb = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock,
// carry kept in a register between passes, start/ready/done handshake.
module serial_adder
    import serial_adder_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [CHUNK-1:0] cx, cy, cs;
    logic             cc, cm;
    logic [WIDTH-1:0] res_nxt;

    assign last = (cnt == LAST);
    assign cx   = opa[int'(cnt)*CHUNK +: CHUNK];
    assign cy   = opb[int'(cnt)*CHUNK +: CHUNK];

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x     (cx),
        .y     (cy),
        .cin   (carry),
        .s     (cs),
        .cout  (cc),
        .c_msb (cm)
    );

    // Completed result: current chunk on top of the previously produced chunks.
    if (N == 1) begin : g_single
        assign res_nxt = cs;
    end else begin : g_multi
        logic [WIDTH-CHUNK-1:0] res_sr;

        // Shift each finished chunk in from the top; after N-1 passes the
        // register holds every chunk but the last, already in position.
        // NOTE: this register is reset like the others even though it is always
        // overwritten before use, so simulation never shows X after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_sr <= '0;
            end else if (state == ST_RUN) begin
                res_sr <= res_nxt[WIDTH-1:CHUNK];
            end
        end

        assign res_nxt = {cs, res_sr};
    end

    // State register.
    // NOTE: sequential logic uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last chunk.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-chunk carry/counter update and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction as a + ~b + 1: invert B, seed carry with 1.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    carry <= cc;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum <= res_nxt;
                        co  <= cc;
                        ovf <= cc ^ cm;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at CHUNK = 4, 16 and 1 (WIDTH = 16).
// The driver pushes hand-computed results; per-instance monitors pop on done.
module tb_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        start4 = 1'b0, start16 = 1'b0, start1 = 1'b0;

    logic        ready4, done4, co4, ovf4;
    logic        ready16, done16, co16, ovf16;
    logic        ready1, done1, co1, ovf1;
    logic [15:0] sum4, sum16, sum1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_accept = 0;
    exp_t q4[$], q16[$], q1[$];

    serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b),
        .ready(ready4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4)
    );

    serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .a(a), .b(b),
        .ready(ready16), .done(done16), .sum(sum16), .co(co16), .ovf(ovf16)
    );

    serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b),
        .ready(ready1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [15:0] s,
                         input logic c, input logic o, input logic rdy);
        check({tag, "_sum"},        32'(s),   32'(e.sum));
        check({tag, "_co"},         32'(c),   32'(e.co));
        check({tag, "_ovf"},        32'(o),   32'(e.ovf));
        check({tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        check({tag, "_ready_in_done"}, 32'(rdy), 32'd0);
    endtask

    // Monitors: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done4 === 1'b1) begin
            check("c4_done_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) score("c4", q4.pop_front(), sum4, co4, ovf4, ready4);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done16 === 1'b1) begin
            check("c16_done_expected", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) score("c16", q16.pop_front(), sum16, co16, ovf16, ready16);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            check("c1_done_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) score("c1", q1.pop_front(), sum1, co1, ovf1, ready1);
        end
    end

    function automatic logic rdy(input int idx);
        case (idx)
            0:       return ready4;
            1:       return ready16;
            default: return ready1;
        endcase
    endfunction

    task automatic set_start(input int idx, input logic v);
        case (idx)
            0:       start4 = v;
            1:       start16 = v;
            default: start1 = v;
        endcase
    endtask

    // idx 0 = CHUNK 4 (N=4), 1 = CHUNK 16 (N=1), 2 = CHUNK 1 (N=16).
    // Called at a falling edge; returns at a falling edge.
    task automatic issue(input int idx, input logic s_, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input bit push, input bit garbage, input int spacing);
        int   n;
        bit   ok;
        exp_t e;
        n  = (idx == 0) ? 4 : (idx == 1) ? 1 : 16;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (rdy(idx) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ready_wait", 32'(ok), 32'd1);
        sub = s_;
        a   = x;
        b   = y;
        set_start(idx, 1'b1);
        @(posedge clk);
        #1;
        check("ready_fall", 32'(rdy(idx)), 32'd0);
        if (spacing > 0) check("start_spacing", 32'(cyc - last_accept), 32'(spacing));
        last_accept = cyc;
        if (push) begin
            e.sum = es; e.co = ec; e.ovf = eo; e.done_cyc = cyc + n;
            case (idx)
                0:       q4.push_back(e);
                1:       q16.push_back(e);
                default: q1.push_back(e);
            endcase
        end
        @(negedge clk);
        if (garbage) begin
            // Keep start high and scramble operands through RUN and DONE.
            for (int i = 0; i <= n; i++) begin
                sub = 1'($urandom);
                a   = 16'($urandom);
                b   = 16'($urandom);
                set_start(idx, 1'b1);
                @(negedge clk);
            end
        end
        set_start(idx, 1'b0);
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic arith_set(input int idx);
        issue(idx, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        issue(idx, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        issue(idx, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        issue(idx, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        issue(idx, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready4), 32'd1);
        check("rst_done",  32'(done4),  32'd0);
        check("rst_sum",   32'(sum4),   32'd0);
        check("rst_co",    32'(co4),    32'd0);
        check("rst_ovf",   32'(ovf4),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic at CHUNK = 4.
        arith_set(0);

        // Robustness: start held high and operands scrambled during RUN/DONE.
        issue(0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        issue(0, 1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 6);
        issue(0, 1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 6);
        issue(0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0, 6);

        // Reset after edge 2 of a run: outputs clear at once, no done follows.
        issue(0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_sum",   32'(sum4),   32'd0);
        check("midrun_rst_co",    32'(co4),    32'd0);
        check("midrun_rst_ovf",   32'(ovf4),   32'd0);
        check("midrun_rst_ready", 32'(ready4), 32'd1);
        check("midrun_rst_done",  32'(done4),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Single-pass and bit-serial configurations.
        arith_set(1);
        arith_set(2);

        repeat (40) @(negedge clk);
        check("c4_queue_drained",  32'(q4.size()),  32'd0);
        check("c16_queue_drained", 32'(q16.size()), 32'd0);
        check("c1_queue_drained",  32'(q1.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised add/subtract unit: it processes a WIDTH-bit operand pair CHUNK bits per clock and carries between chunks in a register. It reports the sum, carry/borrow and signed overflow, using a start/ready/done handshake. It sits beside the PS/2 and VGA logic as a small-area arithmetic engine, for example for cursor and coordinate updates, where a full-width ripple adder is not needed.

## Interface
- WIDTH, 16: operand/result width in bits; ≥ 2.
- CHUNK, 4: bits processed per cycle; must divide WIDTH; CHUNK = WIDTH is legal (single-pass).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while ready = 1.
- sub  input  1  0 = a + b, 1 = a − b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; sum/co/ovf valid from this cycle.
- sum  output  WIDTH  result; held until the next result is written.
- co  output  1  carry out of MSB. For sub, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/CHUNK passes. Cycle counter width is clog2(N), min 1.
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start = 1 at an edge:
  - latch opA = a and opB = (sub ? ~b : b);
  - carry register = sub;
  - counter = 0;
  - go to RUN.
- IDLE, start = 0: stay in IDLE. sum/co/ovf hold.
- RUN, each edge:
  - add chunk [counter*CHUNK +: CHUNK] of opA, opB and carry;
  - store the chunk result into the internal result shift register;
  - update carry;
  - increment counter.
- RUN, final edge (counter = N−1):
  - write sum, co and ovf;
  - go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE on the next edge.
- start outside IDLE is ignored. It is neither queued nor latched, and a, b and sub may change freely.
- Arithmetic is modulo 2^WIDTH. No saturation.
- ovf uses the carry into bit WIDTH−1 from the final chunk.
- Reset, asserted at any time including mid-RUN:
  - state = IDLE; ready = 1; done = 0; sum = 0; co = 0; ovf = 0;
  - operand, carry and counter registers cleared;
  - any in-flight operation is discarded.

## Timing
- The edge that samples start is edge 0. Chunk k (k = 0..N−1) is processed at edge k+1.
- sum/co/ovf update at edge N. done = 1 between edge N and edge N+1.
- ready falls after edge 0 and rises after edge N+1.
- Minimum start-to-start spacing is N+2 cycles.
- sum/co/ovf are registered outputs. There is no combinational path from the inputs to any output.
- Reset is asynchronous on assertion. Deassertion is assumed to be synchronised externally. The first start can be accepted at the first edge after rst_n rises.

## Structure
- Shared package/include `serial_adder_defs`:
  - 2-bit state encodings ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2;
  - the clog2 helper function.
- Sub-module `adder_chunk`, combinational, parameter CHUNK:
  - inputs x[CHUNK], y[CHUNK], cin;
  - outputs s[CHUNK], cout, c_msb (the carry into the top bit, used for ovf).
- The top level holds the FSM, counter, operand and result shift registers, and output registers.
- Parameter checks (WIDTH % CHUNK == 0, WIDTH ≥ 2) are made at elaboration.

## Test plan
All scenarios use WIDTH = 16 and CHUNK = 4 unless stated.
- Add: 0x1234 + 0x0FFF → sum = 0x2233, co = 0, ovf = 0. done at edge 4; ready back after edge 5.
- Signed overflow: 0x7FFF + 0x0001 → 0x8000, co = 0, ovf = 1.
- Carry wrap: 0xFFFF + 0x0001 → 0x0000, co = 1, ovf = 0.
- Subtract: 0x0005 − 0x0007 → 0xFFFE, co = 0, ovf = 0. Also 0x8000 − 0x0001 → 0x7FFF, co = 1, ovf = 1.
- Robustness, start pulsed and operands changed every cycle during RUN/DONE:
  - the result still matches the first sampled pair;
  - exactly one done pulse per accepted start;
  - back-to-back requests are spaced 6 cycles.
  - Reset mid-RUN after edge 2: all outputs go to 0 and ready = 1 immediately, with no done. A new start then completes correctly.
  - Repeat the arithmetic cases at CHUNK = 16 (done at edge 1) and CHUNK = 1 (done at edge 16).
